// File: rtl/tea_codec_stream.sv
// tea_codec_stream: AXI4-Stream TEA encrypt/decrypt engine.
// LANES 64-bit blocks per beat, one TEA round per clock.
module tea_codec_stream #(
  parameter int          LANES              = 1,
  parameter int          STREAM_WIDTH_DATA  = 64*LANES,
  parameter int          STREAM_WIDTH_DS    = STREAM_WIDTH_DATA/8,
  parameter int          STREAM_WIDTH_TID   = 8,
  parameter int          STREAM_WIDTH_TDEST = 3,
  parameter int          STREAM_WIDTH_TUSER = 1,
  parameter int          NUM_ROUNDS         = 32,
  parameter logic [31:0] DELTA              = 32'h9E3779B9
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic                          CFG_DECRYPT,
  input  logic [127:0]                  CFG_KEY,
  output logic                          S_TREADY,
  input  logic                          S_TVALID,
  input  logic [STREAM_WIDTH_DATA-1:0]  S_TDATA,
  input  logic [STREAM_WIDTH_DS-1:0]    S_TSTRB,
  input  logic [STREAM_WIDTH_DS-1:0]    S_TKEEP,
  input  logic                          S_TLAST,
  input  logic [STREAM_WIDTH_TID-1:0]   S_TID,
  input  logic [STREAM_WIDTH_TDEST-1:0] S_TDEST,
`ifdef AMBA_AXI_TUSER
  input  logic [STREAM_WIDTH_TUSER-1:0] S_TUSER,
  output logic [STREAM_WIDTH_TUSER-1:0] M_TUSER,
`endif
  input  logic                          M_TREADY,
  output logic                          M_TVALID,
  output logic [STREAM_WIDTH_DATA-1:0]  M_TDATA,
  output logic [STREAM_WIDTH_DS-1:0]    M_TSTRB,
  output logic [STREAM_WIDTH_DS-1:0]    M_TKEEP,
  output logic                          M_TLAST,
  output logic [STREAM_WIDTH_TID-1:0]   M_TID,
  output logic [STREAM_WIDTH_TDEST-1:0] M_TDEST
);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 255) begin : g_bad_rounds
    $error("tea_codec_stream: NUM_ROUNDS must be 1..255");
  end

  if (STREAM_WIDTH_DATA != 64*LANES) begin : g_bad_width
    $error("tea_codec_stream: STREAM_WIDTH_DATA must be 64*LANES");
  end

  if (STREAM_WIDTH_TUSER < 1) begin : g_bad_tuser
    $error("tea_codec_stream: STREAM_WIDTH_TUSER must be >= 1");
  end

  localparam logic [63:0] SUM_FULL =
    64'(DELTA) * 64'(NUM_ROUNDS);
  localparam logic [31:0] SUM_DEC  = SUM_FULL[31:0];
  localparam logic [7:0]  RND_LAST = 8'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                         state_q;
  state_t                         state_d;
  logic [7:0]                     rnd_q;
  logic                           last_rnd;
  logic                           accept;
  logic [STREAM_WIDTH_DATA-1:0]   data_q;
  logic [STREAM_WIDTH_DATA-1:0]   data_rnd;
  logic [127:0]                   key_q;
  logic                           dec_q;
  logic [31:0]                    sum_q;
  logic [31:0]                    sum_enc;
  logic [31:0]                    sum_nx;

  function automatic logic [31:0] mix(
    input logic [31:0] v,
    input logic [31:0] s,
    input logic [31:0] ka,
    input logic [31:0] kb
  );
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

  function automatic logic [63:0] enc_lane(
    input logic [63:0]  v,
    input logic [127:0] k,
    input logic [31:0]  s
  );
    logic [31:0] y;
    logic [31:0] z;
    y = v[63:32] + mix(v[31:0], s, k[127:96], k[95:64]);
    z = v[31:0] + mix(y, s, k[63:32], k[31:0]);
    return {y, z};
  endfunction

  function automatic logic [63:0] dec_lane(
    input logic [63:0]  v,
    input logic [127:0] k,
    input logic [31:0]  s
  );
    logic [31:0] y;
    logic [31:0] z;
    z = v[31:0] - mix(v[63:32], s, k[63:32], k[31:0]);
    y = v[63:32] - mix(z, s, k[127:96], k[95:64]);
    return {y, z};
  endfunction

  assign last_rnd = (rnd_q == RND_LAST);
  assign accept   = S_TVALID & S_TREADY;
  assign M_TDATA  = data_q;

  // state register
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and handshake outputs
  always_comb begin
    state_d  = state_q;
    S_TREADY = 1'b0;
    M_TVALID = 1'b0;
    unique case (state_q)
      IDLE: begin
        S_TREADY = ARESETn;
        if (S_TVALID) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_rnd) begin
          state_d = OUT;
        end
      end
      OUT: begin
        M_TVALID = 1'b1;
        S_TREADY = ARESETn & M_TREADY;
        if (M_TREADY) begin
          state_d = S_TVALID ? RUN : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // one TEA round on every lane, mode from the latched beat
  always_comb begin
    sum_enc  = sum_q + DELTA;
    sum_nx   = dec_q ? (sum_q - DELTA) : sum_enc;
    data_rnd = data_q;
    for (int i = 0; i < LANES; i++) begin
      if (dec_q) begin
        data_rnd[64*i +: 64] =
          dec_lane(data_q[64*i +: 64], key_q, sum_q);
      end else begin
        data_rnd[64*i +: 64] =
          enc_lane(data_q[64*i +: 64], key_q, sum_enc);
      end
    end
  end

  // beat capture, round iteration and round counter
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      data_q <= '0;
      key_q  <= '0;
      dec_q  <= 1'b0;
      sum_q  <= '0;
      rnd_q  <= '0;
    end else if (accept) begin
      data_q <= S_TDATA;
      key_q  <= CFG_KEY;
      dec_q  <= CFG_DECRYPT;
      sum_q  <= CFG_DECRYPT ? SUM_DEC : 32'h0;
      rnd_q  <= '0;
    end else if (state_q == RUN) begin
      data_q <= data_rnd;
      sum_q  <= sum_nx;
      rnd_q  <= last_rnd ? 8'h0 : rnd_q + 8'h1;
    end
  end

  // sideband travels with its beat
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      M_TSTRB <= '0;
      M_TKEEP <= '0;
      M_TLAST <= 1'b0;
      M_TID   <= '0;
      M_TDEST <= '0;
    end else if (accept) begin
      M_TSTRB <= S_TSTRB;
      M_TKEEP <= S_TKEEP;
      M_TLAST <= S_TLAST;
      M_TID   <= S_TID;
      M_TDEST <= S_TDEST;
    end
  end

`ifdef AMBA_AXI_TUSER
  // user sideband travels with its beat
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      M_TUSER <= '0;
    end else if (accept) begin
      M_TUSER <= S_TUSER;
    end
  end
`endif

endmodule

// File: tb/tb_tea_codec_stream.sv
// tb_tea_codec_stream: scoreboard bench for tea_codec_stream,
// a 4-lane 32-round engine and a 1-lane 1-round engine.
module tb_tea_codec_stream;

  localparam int          N0    = 32;
  localparam int          N1    = 1;
  localparam logic [31:0] DELTA = 32'h9E3779B9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errs = 0;
  int   chks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic         cfg_dec0;
  logic [127:0] cfg_key0;
  logic         s_rdy0;
  logic         s_vld0;
  logic [255:0] s_dat0;
  logic [31:0]  s_strb0;
  logic [31:0]  s_keep0;
  logic         s_last0;
  logic [7:0]   s_tid0;
  logic [2:0]   s_dest0;
  logic         m_rdy0;
  logic         m_vld0;
  logic [255:0] m_dat0;
  logic [31:0]  m_strb0;
  logic [31:0]  m_keep0;
  logic         m_last0;
  logic [7:0]   m_tid0;
  logic [2:0]   m_dest0;

  logic         cfg_dec1;
  logic [127:0] cfg_key1;
  logic         s_rdy1;
  logic         s_vld1;
  logic [63:0]  s_dat1;
  logic [7:0]   s_strb1;
  logic [7:0]   s_keep1;
  logic         s_last1;
  logic [7:0]   s_tid1;
  logic [2:0]   s_dest1;
  logic         m_rdy1;
  logic         m_vld1;
  logic [63:0]  m_dat1;
  logic [7:0]   m_strb1;
  logic [7:0]   m_keep1;
  logic         m_last1;
  logic [7:0]   m_tid1;
  logic [2:0]   m_dest1;

`ifdef AMBA_AXI_TUSER
  logic s_user0 = 1'b0;
  logic m_user0;
  logic s_user1 = 1'b0;
  logic m_user1;
`endif

  tea_codec_stream #(
    .LANES      (4),
    .NUM_ROUNDS (N0)
  ) u_dut0 (
    .ACLK        (clk),
    .ARESETn     (rst_n),
    .CFG_DECRYPT (cfg_dec0),
    .CFG_KEY     (cfg_key0),
    .S_TREADY    (s_rdy0),
    .S_TVALID    (s_vld0),
    .S_TDATA     (s_dat0),
    .S_TSTRB     (s_strb0),
    .S_TKEEP     (s_keep0),
    .S_TLAST     (s_last0),
    .S_TID       (s_tid0),
    .S_TDEST     (s_dest0),
`ifdef AMBA_AXI_TUSER
    .S_TUSER     (s_user0),
    .M_TUSER     (m_user0),
`endif
    .M_TREADY    (m_rdy0),
    .M_TVALID    (m_vld0),
    .M_TDATA     (m_dat0),
    .M_TSTRB     (m_strb0),
    .M_TKEEP     (m_keep0),
    .M_TLAST     (m_last0),
    .M_TID       (m_tid0),
    .M_TDEST     (m_dest0)
  );

  tea_codec_stream #(
    .LANES      (1),
    .NUM_ROUNDS (N1)
  ) u_dut1 (
    .ACLK        (clk),
    .ARESETn     (rst_n),
    .CFG_DECRYPT (cfg_dec1),
    .CFG_KEY     (cfg_key1),
    .S_TREADY    (s_rdy1),
    .S_TVALID    (s_vld1),
    .S_TDATA     (s_dat1),
    .S_TSTRB     (s_strb1),
    .S_TKEEP     (s_keep1),
    .S_TLAST     (s_last1),
    .S_TID       (s_tid1),
    .S_TDEST     (s_dest1),
`ifdef AMBA_AXI_TUSER
    .S_TUSER     (s_user1),
    .M_TUSER     (m_user1),
`endif
    .M_TREADY    (m_rdy1),
    .M_TVALID    (m_vld1),
    .M_TDATA     (m_dat1),
    .M_TSTRB     (m_strb1),
    .M_TKEEP     (m_keep1),
    .M_TLAST     (m_last1),
    .M_TID       (m_tid1),
    .M_TDEST     (m_dest1)
  );

  typedef struct {
    logic [255:0] d;
    logic [31:0]  strb;
    logic [31:0]  keep;
    logic         last;
    logic [7:0]   tid;
    logic [2:0]   dest;
    int           acc;
  } exp_t;

  exp_t        q0[$];
  logic [63:0] q1[$];
  int          a1[$];

  logic [255:0] last_out0;
  logic [63:0]  last_out1;
  int           mhs_cyc = -1;
  int           rmode = 2;

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    chks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input string msg);
    chks++;
    errs++;
    $display("FAIL %s: %s", nm, msg);
  endtask

  // Plain TEA on one 64-bit block, straight from the algorithm.
  function automatic logic [63:0] tea_ref(input logic [63:0] b,
                                          input logic [127:0] k,
                                          input logic dec,
                                          input int n);
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] s;
    y = b[63:32];
    z = b[31:0];
    s = 32'h0;
    if (!dec) begin
      for (int r = 0; r < n; r++) begin
        s = s + DELTA;
        y = y + (((z << 4) + k[127:96]) ^ (z + s)
                 ^ ((z >> 5) + k[95:64]));
        z = z + (((y << 4) + k[63:32]) ^ (y + s)
                 ^ ((y >> 5) + k[31:0]));
      end
    end else begin
      for (int r = 0; r < n; r++) s = s + DELTA;
      for (int r = 0; r < n; r++) begin
        z = z - (((y << 4) + k[63:32]) ^ (y + s)
                 ^ ((y >> 5) + k[31:0]));
        y = y - (((z << 4) + k[127:96]) ^ (z + s)
                 ^ ((z >> 5) + k[95:64]));
        s = s - DELTA;
      end
    end
    return {y, z};
  endfunction

  function automatic logic [255:0] ref0(input logic [255:0] d,
                                        input logic [127:0] k,
                                        input logic dec);
    logic [255:0] r;
    for (int i = 0; i < 4; i++)
      r[64*i +: 64] = tea_ref(d[64*i +: 64], k, dec, N0);
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Output-side ready: random, held low or held high.
  always @(posedge clk) begin
    #2;
    case (rmode)
      0:       m_rdy0 = ($urandom_range(0, 3) != 0);
      1:       m_rdy0 = 1'b0;
      default: m_rdy0 = 1'b1;
    endcase
  end

  // Monitor for the 4-lane engine.
  logic         pv0 = 1'b0;
  logic         ph0 = 1'b0;
  logic         vld0;
  logic         hs0;
  logic [75:0]  sb0;
  logic [75:0]  hold_sb0;
  logic [255:0] hold_d0;
  exp_t         e0;

  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      pv0 = 1'b0;
      ph0 = 1'b0;
    end else begin
      vld0 = m_vld0;
      hs0  = vld0 && m_rdy0;
      sb0  = {m_strb0, m_keep0, m_last0, m_tid0, m_dest0};
      if (vld0 && (!pv0 || ph0)) begin
        if (q0.size() == 0)
          fail("spurious0", "M_TVALID with nothing expected");
        else
          chk_i("latency0", cyc - q0[0].acc, N0 + 1);
      end
      if (vld0 && pv0 && !ph0) begin
        chk("hold_data0", m_dat0, hold_d0);
        chk("hold_side0", 256'(sb0), 256'(hold_sb0));
      end
      if (vld0 && !m_rdy0)
        chk("bp_sready0", 256'(s_rdy0), 256'(0));
      if (hs0 && q0.size() != 0) begin
        e0 = q0.pop_front();
        chk("data0", m_dat0, e0.d);
        chk("side0", 256'(sb0),
            256'({e0.strb, e0.keep, e0.last, e0.tid, e0.dest}));
        last_out0 = m_dat0;
        mhs_cyc   = cyc;
      end
      pv0      = vld0;
      ph0      = hs0;
      hold_d0  = m_dat0;
      hold_sb0 = sb0;
    end
  end

  // Monitor for the 1-round engine (always ready).
  logic [63:0] x1;
  int          t1;

  always begin
    @(negedge clk);
    #2;
    if (rst_n && m_vld1) begin
      if (q1.size() == 0) begin
        fail("spurious1", "M_TVALID with nothing expected");
      end else begin
        x1 = q1.pop_front();
        t1 = a1.pop_front();
        chk_i("latency1", cyc - t1, N1 + 1);
        chk("data1", 256'(m_dat1), 256'(x1));
        last_out1 = m_dat1;
      end
    end
  end

  task automatic send0(input logic [255:0] d,
                       input logic dec,
                       input logic [127:0] k,
                       input logic [7:0] tid,
                       input logic [2:0] dest,
                       input logic last,
                       input logic [31:0] keep,
                       input logic [31:0] strb,
                       output int acc);
    exp_t e;
    int   n;
    s_dat0 = d;   cfg_dec0 = dec; cfg_key0 = k;
    s_tid0 = tid; s_dest0 = dest; s_last0 = last;
    s_keep0 = keep; s_strb0 = strb;
    s_vld0 = 1'b1;
    acc = -1;
    n = 0;
    while (acc < 0 && n < 500) begin
      #1;
      if (s_rdy0) begin
        acc    = cyc;
        e.d    = ref0(d, k, dec);
        e.strb = strb; e.keep = keep; e.last = last;
        e.tid  = tid;  e.dest = dest; e.acc = cyc;
        q0.push_back(e);
      end
      @(negedge clk);
      n++;
    end
    if (acc < 0) fail("send0_timeout", "S handshake never happened");
    s_vld0   = 1'b0;
    cfg_dec0 = 1'($urandom_range(0, 1));
    cfg_key0 = rnd128();
  endtask

  task automatic send0_rnd();
    int a;
    send0(rnd256(), 1'($urandom_range(0, 1)), rnd128(),
          8'($urandom), 3'($urandom), 1'($urandom_range(0, 1)),
          $urandom, $urandom, a);
  endtask

  // Idle cycles with the config inputs scrambled every cycle.
  task automatic idle0(input int n);
    repeat (n) begin
      cfg_dec0 = 1'($urandom_range(0, 1));
      cfg_key0 = rnd128();
      @(negedge clk);
    end
  endtask

  task automatic drain0();
    int n = 0;
    while ((q0.size() != 0 || m_vld0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail("drain0_timeout", "output never drained");
  endtask

  task automatic send1(input logic [63:0] d,
                       input logic dec,
                       input logic [127:0] k,
                       input logic [63:0] exp);
    int n = 0;
    bit done = 0;
    s_dat1 = d; cfg_dec1 = dec; cfg_key1 = k;
    s_vld1 = 1'b1;
    while (!done && n < 100) begin
      #1;
      if (s_rdy1) begin
        done = 1;
        q1.push_back(exp);
        a1.push_back(cyc);
      end
      @(negedge clk);
      n++;
    end
    if (!done) fail("send1_timeout", "S handshake never happened");
    s_vld1   = 1'b0;
    cfg_dec1 = ~cfg_dec1;
    cfg_key1 = rnd128();
  endtask

  task automatic drain1();
    int n = 0;
    while ((q1.size() != 0 || m_vld1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail("drain1_timeout", "output never drained");
  endtask

  localparam logic [63:0] CT0 = 64'h41EA3A0A_94BAA940;
  localparam logic [63:0] PT  = 64'h01234567_89ABCDEF;

  logic [255:0] d;
  logic [255:0] c;
  logic [127:0] kab;
  logic [63:0]  x;
  logic [63:0]  y;
  logic [127:0] k;
  int           acc_a;
  int           acc_b;

  initial begin
    s_vld0 = 0; s_dat0 = '0; s_strb0 = '0; s_keep0 = '0;
    s_last0 = 0; s_tid0 = '0; s_dest0 = '0;
    cfg_dec0 = 0; cfg_key0 = '0; m_rdy0 = 1'b1;
    s_vld1 = 0; s_dat1 = '0; s_strb1 = 8'hFF; s_keep1 = 8'hFF;
    s_last1 = 1; s_tid1 = 8'h11; s_dest1 = 3'h1;
    cfg_dec1 = 0; cfg_key1 = '0; m_rdy1 = 1'b1;
    kab = {16{8'hAB}};

    repeat (3) @(negedge clk);
    chk("rst_mvalid", 256'(m_vld0), 256'(0));
    chk("rst_mdata", m_dat0, 256'(0));
    chk("rst_mside", 256'({m_tid0, m_dest0, m_last0, m_keep0}),
        256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_sready0", 256'(s_rdy0), 256'(1));
    chk("rst_sready1", 256'(s_rdy1), 256'(1));
    @(negedge clk);

    // Known answer, four independent lanes, sideband passthrough.
    x = 64'hDEADBEEF_CAFEF00D;
    d = {~x, x, CT0, 64'h0};
    send0(d, 1'b0, '0, 8'h5A, 3'h6, 1'b1, '1, '1, acc_a);
    drain0();
    chk("kat_enc", 256'(last_out0[63:0]), 256'(CT0));

    d = {x, ~x, 64'h0, CT0};
    send0(d, 1'b1, '0, 8'hA5, 3'h1, 1'b0, '1, '0, acc_a);
    drain0();
    chk("kat_dec", 256'(last_out0[63:0]), 256'(0));

    // Round trip with the AB key.
    send0({4{PT}}, 1'b0, kab, 8'h01, 3'h2, 1'b1, '1, '1, acc_a);
    drain0();
    c = last_out0;
    send0(c, 1'b1, kab, 8'h02, 3'h3, 1'b1, '1, '1, acc_a);
    drain0();
    chk("roundtrip", last_out0, {4{PT}});

    // Backpressure, then simultaneous M and S handshakes.
    rmode = 1;
    @(negedge clk);
    send0(rnd256(), 1'b0, rnd128(), 8'h33, 3'h4, 1'b0,
          '1, '1, acc_a);
    begin : wait_out
      int n = 0;
      while (!m_vld0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!m_vld0) fail("bp_wait", "M_TVALID never rose");
    end
    fork
      send0(rnd256(), 1'b1, rnd128(), 8'h44, 3'h5, 1'b1,
            '1, '1, acc_b);
      begin
        repeat (10) @(negedge clk);
        rmode = 2;
      end
    join
    #3;
    chk_i("same_cycle_hs", acc_b, mhs_cyc);
    drain0();

    // Config scrambled every cycle while the beat runs.
    send0_rnd();
    idle0(40);
    drain0();

    // Random traffic with random output backpressure.
    rmode = 0;
    for (int i = 0; i < 20; i++) begin
      send0_rnd();
      idle0($urandom_range(0, 2));
    end
    drain0();
    rmode = 2;
    @(negedge clk);

    // Reset at round 10 discards the beat.
    send0_rnd();
    idle0(10);
    rst_n = 1'b0;
    q0.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_mvalid", 256'(m_vld0), 256'(0));
    chk("midrst_sready", 256'(s_rdy0), 256'(1));
    chk("midrst_mdata", m_dat0, 256'(0));
    @(negedge clk);
    idle0(40);
    send0_rnd();
    drain0();

    // Single-round engine: known answer and round trips.
    send1(64'h0, 1'b0, '0, tea_ref(64'h0, '0, 1'b0, N1));
    drain1();
    chk("kat1", 256'(last_out1), 256'(64'h9E3779B9_DBE8D32F));
    for (int i = 0; i < 4; i++) begin
      x = {$urandom, $urandom};
      k = rnd128();
      send1(x, 1'b0, k, tea_ref(x, k, 1'b0, N1));
      drain1();
      y = last_out1;
      send1(y, 1'b1, k, x);
      drain1();
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule

// File: doc/tea_codec_stream.md
Name: tea_codec_stream

Overview:
- AXI4-Stream TEA engine with a runtime mode input: one engine performs either encryption or decryption, selected per beat.
- Parametrised successor to the single-lane, fixed-key stream decryptor.
- Generalised to LANES parallel 64-bit TEA blocks per beat, a configurable round count and a runtime key.
- Iterative datapath, one TEA round per cycle; sits between AXI-Stream master and slave in the stream subsystem.

Parameters:
- LANES, 1, number of 64-bit TEA blocks per beat.
- STREAM_WIDTH_DATA, 64*LANES, TDATA width; fixed by LANES, never overridden independently.
- STREAM_WIDTH_DS, STREAM_WIDTH_DATA/8, TSTRB/TKEEP width.
- STREAM_WIDTH_TID, 8, TID width.
- STREAM_WIDTH_TDEST, 3, TDEST width.
- STREAM_WIDTH_TUSER, 1, TUSER width.
- NUM_ROUNDS, 32, TEA rounds; legal range 1..255.
- DELTA, 32'h9E3779B9, TEA key-schedule constant.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETn  in  1  synchronous active-low reset.
- CFG_DECRYPT  in  1  1 = decrypt, 0 = encrypt; sampled on S handshake.
- CFG_KEY  in  128  key; k0=[127:96], k1=[95:64], k2=[63:32], k3=[31:0]; sampled on S handshake.
- S_TREADY  out  1  slave ready.
- S_TVALID  in  1  slave valid.
- S_TDATA  in  STREAM_WIDTH_DATA  input blocks; lane i = [64i+63:64i]; v0=[64i+63:64i+32], v1=[64i+31:64i].
- S_TSTRB, S_TKEEP  in  STREAM_WIDTH_DS  byte qualifiers.
- S_TLAST  in  1  packet boundary.
- S_TID  in  STREAM_WIDTH_TID  stream id.
- S_TDEST  in  STREAM_WIDTH_TDEST  routing.
- S_TUSER  in  STREAM_WIDTH_TUSER  user sideband; present only under AMBA_AXI_TUSER.
- M_TREADY  in  1  master ready.
- M_TVALID  out  1  master valid.
- M_TDATA  out  STREAM_WIDTH_DATA  result blocks, same lane/word layout as S_TDATA.
- M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST  out  as S  captured sideband.
- M_TUSER  out  STREAM_WIDTH_TUSER  captured sideband; present only under AMBA_AXI_TUSER.

Behaviour:
- Reset (ARESETn low at a clock edge), state after that edge:
  - state=IDLE; M_TVALID=0; S_TREADY=1 from the first cycle after reset deasserts.
  - M_TDATA and all M sideband = 0; round counter = 0.
- Reset mid-RUN or mid-OUT: the in-flight beat is discarded, no output is produced, and the block returns to IDLE.
- FSM states:
  - IDLE: S_TREADY=1. On S_TVALID, latch S_TDATA, all sideband, CFG_DECRYPT and CFG_KEY; go to RUN.
  - RUN: S_TREADY=0, M_TVALID=0. One round per cycle on all lanes in parallel. After NUM_ROUNDS cycles go to OUT.
  - OUT: M_TVALID=1; M outputs held stable until the M handshake.
    - On M_TREADY with S_TVALID=1: accept the new beat in the same cycle (S_TREADY=M_TREADY in OUT) and go to RUN.
    - On M_TREADY with S_TVALID=0: go to IDLE.
    - M_TREADY=0: stay in OUT.
- Latency: S handshake at cycle t gives M_TVALID=1 at cycle t+NUM_ROUNDS+1. Throughput is one beat per NUM_ROUNDS+1 cycles.
- Encrypt round, all arithmetic mod 2^32:
  - sum += DELTA
  - v0 += ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1)
  - v1 += ((v0'<<4)+k2) ^ (v0'+sum) ^ ((v0'>>5)+k3), where v0' is the updated v0.
  - sum starts at 0.
- Decrypt round:
  - v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3)
  - v0 -= ((v1'<<4)+k0) ^ (v1'+sum) ^ ((v1'>>5)+k1), where v1' is the updated v1.
  - sum -= DELTA
  - sum starts at (DELTA*NUM_ROUNDS) mod 2^32, constant at elaboration (0xC6EF3720 for 32 rounds).
- Shifts are logical. Both half-updates complete within one cycle.
- Latched mode/key are used for the whole beat; CFG_* changes during RUN/OUT have no effect.
- Sideband (TSTRB, TKEEP, TLAST, TID, TDEST, TUSER) passes through unmodified, aligned with its beat.
- TKEEP/TSTRB never gate computation: all lanes are always processed.
- NUM_ROUNDS outside 1..255 is an elaboration error.

Test Plan:
- Encrypt, key=0, S_TDATA=64'h0, LANES=1 -> M_TDATA=64'h41EA3A0A_94BAA940; M_TVALID rises exactly 33 cycles after the handshake.
- Decrypt, key=0, S_TDATA=64'h41EA3A0A_94BAA940 -> M_TDATA=64'h0. Also the round trip encrypt→decrypt of 64'h01234567_89ABCDEF with key 128'hABAB…AB returns the original value.
- LANES=4, lanes = {0, ciphertext above, X, ~X}, encrypt -> each lane matches its independent single-lane result. TID=8'h5A, TDEST=3'h6, TLAST=1, TKEEP=all-ones appear unchanged on M.
- Backpressure: hold M_TREADY=0 for 10 cycles in OUT -> M_TDATA and sideband stable, S_TREADY=0. Release with S_TVALID=1 -> M and S handshakes occur in the same cycle, and the next M_TVALID rises 33 cycles later.
- Toggle CFG_DECRYPT and CFG_KEY every cycle during RUN -> output equals the result for the values latched at acceptance.
- Assert ARESETn=0 at round 10 of RUN -> M_TVALID=0 and S_TREADY=1 one cycle after release, no stale beat emitted. Repeat with NUM_ROUNDS=1: latency 2 cycles, encrypt/decrypt round trip holds.
